// File: rtl/spell_stack_unit.sv
// Parametrised data stack: one micro-op per cycle, with either a checked (saturating,
// error-flagging) or a legacy wrapping stack pointer, plus a debug peek port.
module spell_stack_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WRAP  = 0,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned SPW  = (WRAP != 0) ? AW : AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_op_valid,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_din_a,
    input  logic [WIDTH-1:0] i_din_b,
    output logic [WIDTH-1:0] o_top,
    output logic [WIDTH-1:0] o_below,
    output logic [SPW-1:0]   o_sp,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_op_done,
    output logic             o_err_overflow,
    output logic             o_err_underflow,
    output logic [2:0]       o_err_op,
    input  logic [AW-1:0]    i_dbg_idx,
    output logic [WIDTH-1:0] o_dbg_data,
    output logic             o_dbg_valid
);

    typedef enum logic [2:0] {
        OpNop    = 3'd0,
        OpPush   = 3'd1,
        OpPop    = 3'd2,
        OpBinop  = 3'd3,
        OpSetTop = 3'd4,
        OpSetTwo = 3'd5,
        OpDup    = 3'd6,
        OpSwap   = 3'd7
    } op_e;

    localparam bit           Wrap   = (WRAP != 0);
    localparam logic [SPW:0] DepthW = (SPW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic             r_op_done;
    logic             r_err_ovf;
    logic             r_err_unf;
    logic [2:0]       r_err_op;

    logic [AW-1:0]    w_idx_n;
    logic [AW-1:0]    w_idx_m1;
    logic [AW-1:0]    w_idx_m2;
    logic [AW-1:0]    w_idx_dbg;
    logic             w_ge1;
    logic             w_ge2;
    logic             w_room;

    logic             w_accept;
    logic             w_ovf;
    logic             w_unf;
    logic [SPW-1:0]   w_sp_next;
    logic             w_we_a;
    logic [AW-1:0]    w_addr_a;
    logic [WIDTH-1:0] w_data_a;
    logic             w_we_b;
    logic [AW-1:0]    w_addr_b;
    logic [WIDTH-1:0] w_data_b;

    // Entry indices are taken modulo DEPTH; in checked mode only in-range ones get used.
    assign w_idx_n  = r_sp[AW-1:0];
    assign w_idx_m1 = w_idx_n - AW'(1);
    assign w_idx_m2 = w_idx_n - AW'(2);
    assign w_ge1    = (r_sp != '0);
    assign w_ge2    = ({1'b0, r_sp} >= (SPW + 1)'(2));
    assign w_room   = ({1'b0, r_sp} < DepthW);

    always_comb begin
        w_accept  = 1'b0;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        w_sp_next = r_sp;
        w_we_a    = 1'b0;
        w_addr_a  = w_idx_m1;
        w_data_a  = i_din_a;
        w_we_b    = 1'b0;
        w_addr_b  = w_idx_m2;
        w_data_b  = i_din_b;
        if (i_op_valid && !i_clear) begin
            case (op_e'(i_op))
                OpNop: w_accept = 1'b1;
                OpPush: begin
                    if (Wrap || w_room) begin
                        w_accept  = 1'b1;
                        w_we_a    = 1'b1;
                        w_addr_a  = w_idx_n;
                        w_sp_next = r_sp + SPW'(1);
                    end else begin
                        w_ovf = 1'b1;
                    end
                end
                OpPop: begin
                    if (Wrap || w_ge1) begin
                        w_accept  = 1'b1;
                        w_sp_next = r_sp - SPW'(1);
                    end else begin
                        w_unf = 1'b1;
                    end
                end
                OpBinop: begin
                    if (Wrap || w_ge2) begin
                        w_accept  = 1'b1;
                        w_we_a    = 1'b1;
                        w_addr_a  = w_idx_m2;
                        w_sp_next = r_sp - SPW'(1);
                    end else begin
                        w_unf = 1'b1;
                    end
                end
                OpSetTop: begin
                    if (Wrap || w_ge1) begin
                        w_accept = 1'b1;
                        w_we_a   = 1'b1;
                    end else begin
                        w_unf = 1'b1;
                    end
                end
                OpSetTwo: begin
                    if (Wrap || w_ge2) begin
                        w_accept = 1'b1;
                        w_we_a   = 1'b1;
                        w_we_b   = 1'b1;
                    end else begin
                        w_unf = 1'b1;
                    end
                end
                OpDup: begin
                    if (Wrap || (w_ge1 && w_room)) begin
                        w_accept  = 1'b1;
                        w_we_a    = 1'b1;
                        w_addr_a  = w_idx_n;
                        w_data_a  = r_mem[w_idx_m1];
                        w_sp_next = r_sp + SPW'(1);
                    end else if (!w_ge1) begin
                        w_unf = 1'b1;
                    end else begin
                        w_ovf = 1'b1;
                    end
                end
                OpSwap: begin
                    if (Wrap || w_ge2) begin
                        w_accept = 1'b1;
                        w_we_a   = 1'b1;
                        w_data_a = r_mem[w_idx_m2];
                        w_we_b   = 1'b1;
                        w_data_b = r_mem[w_idx_m1];
                    end else begin
                        w_unf = 1'b1;
                    end
                end
                default: w_accept = 1'b0;
            endcase
        end
    end

    // Storage survives clear; only reset zeroes it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we_a) r_mem[w_addr_a] <= w_data_a;
            if (w_we_b) r_mem[w_addr_b] <= w_data_b;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp      <= '0;
            r_op_done <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
            r_err_op  <= '0;
        end else if (i_clear) begin
            r_sp      <= '0;
            r_op_done <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
            r_err_op  <= '0;
        end else begin
            r_op_done <= w_accept;
            if (w_accept) r_sp <= w_sp_next;
            if (w_ovf || w_unf) begin
                if (!r_err_ovf && !r_err_unf) r_err_op <= i_op;
                r_err_ovf <= r_err_ovf | w_ovf;
                r_err_unf <= r_err_unf | w_unf;
            end
        end
    end

    assign w_idx_dbg       = w_idx_m1 - i_dbg_idx;
    assign o_top           = w_ge1 ? r_mem[w_idx_m1] : '0;
    assign o_below         = w_ge2 ? r_mem[w_idx_m2] : '0;
    assign o_sp            = r_sp;
    assign o_empty         = !w_ge1;
    assign o_full          = Wrap ? 1'b0 : ({1'b0, r_sp} == DepthW);
    assign o_op_done       = r_op_done;
    assign o_err_overflow  = r_err_ovf;
    assign o_err_underflow = r_err_unf;
    assign o_err_op        = r_err_op;
    assign o_dbg_valid     = Wrap ? 1'b1 : (SPW'(i_dbg_idx) < r_sp);
    assign o_dbg_data      = o_dbg_valid ? r_mem[w_idx_dbg] : '0;

endmodule

// File: doc/spell_stack_unit.md
Name: spell_stack_unit

Overview:
Parametrised data-stack unit for the next-generation spell core. It replaces the fixed 32x8 stack array, which silently wraps its stack pointer, with a block of configurable width and depth. The block executes one stack micro-op per cycle on behalf of the execute stage. In checked mode it detects overflow and underflow and rejects the offending op. A read-only debug peek port exposes any live entry for the shift-register dump path.

Parameters:
WIDTH, 8, bits per stack entry
DEPTH, 32, number of entries; must be a power of two, 2..256
WRAP, 0, 0 = checked mode (sp saturates, errors flagged); 1 = legacy mode (sp wraps modulo DEPTH, no errors)
SPW, derived, sp width: $clog2(DEPTH)+1 when WRAP=0, $clog2(DEPTH) when WRAP=1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous stack flush
op_valid  in  1  execute op this cycle
op  in  3  0 NOP, 1 PUSH, 2 POP, 3 BINOP (pop2 push1), 4 SET_TOP, 5 SET_TWO, 6 DUP, 7 SWAP
din_a  in  WIDTH  value for new top
din_b  in  WIDTH  value for new below-top (SET_TWO only)
top  out  WIDTH  stack[sp-1]; 0 when empty
below  out  WIDTH  stack[sp-2]; 0 when count<2
sp  out  SPW  current entry count / pointer
empty  out  1  sp==0
full  out  1  sp==DEPTH (checked mode); constant 0 when WRAP=1
op_done  out  1  pulse, cycle after an accepted op
err_overflow  out  1  sticky, checked mode only
err_underflow  out  1  sticky, checked mode only
err_op  out  3  op code of the first rejected op
dbg_idx  in  $clog2(DEPTH)  depth below top (0 = top)
dbg_data  out  WIDTH  stack[sp-1-dbg_idx]
dbg_valid  out  1  dbg_idx < sp (always 1 when WRAP=1)

Behaviour:
- Reset, asynchronous: sp=0, all entries=0, op_done=0, err flags=0, err_op=0. Reset mid-op discards the op.
- Accepted ops update storage and sp at the next clk edge. top/below/sp/empty/full reflect the new state in the following cycle (1-cycle latency).
- top, below, dbg_data: combinational reads of registered state.
- Op effects (n = sp):
  - PUSH: [n]=din_a, sp=n+1.
  - POP: sp=n-1.
  - BINOP: [n-2]=din_a, sp=n-1.
  - SET_TOP: [n-1]=din_a.
  - SET_TWO: [n-1]=din_a, [n-2]=din_b.
  - DUP: [n]=[n-1], sp=n+1.
  - SWAP: exchange [n-1] and [n-2].
  - NOP: no change; still pulses op_done.
- Checked-mode requirements:
  - PUSH: n<DEPTH.
  - POP, SET_TOP: n>=1.
  - BINOP, SET_TWO, SWAP: n>=2.
  - DUP: n>=1 and n<DEPTH.
- Checked-mode violation:
  - Op fully suppressed: no storage or sp change, no op_done.
  - err_overflow or err_underflow set.
  - err_op captured only if both flags were clear before.
  - DUP on an empty stack flags underflow. DUP on a full stack flags overflow.
- WRAP=1: all index arithmetic is modulo DEPTH, and nothing is rejected. The legacy example is POP at sp=0 giving sp=DEPTH-1.
- clear: sp=0 and err flags/err_op cleared; entry contents retained. clear has priority over a simultaneous op_valid, which is ignored (no op_done).
- op_valid with op held several cycles executes once per cycle.
- Read-during-write: top reflects the old state in the cycle the op is presented.

Test Plan:
- Reset, then PUSH 0x11, 0x22, 0x33 on consecutive cycles -> sp=3, top=0x33, below=0x22, op_done high 3 cycles; dbg_idx=2 gives dbg_data=0x11, dbg_valid=1.
- From [0x11,0x22,0x33]: SWAP -> top=0x22, below=0x33. Then BINOP din_a=0x55 -> sp=2, top=0x55, below=0x11. Then DUP -> sp=3, top=below=0x55.
- WRAP=0, DEPTH=4: 4 PUSHes, then PUSH 0xAA -> full=1, sp=4, top unchanged, err_overflow=1, err_op=1, no op_done. Then POP x4, then POP -> err_underflow=1, err_op still 1.
- WRAP=1, DEPTH=32: POP at sp=0 -> sp=31, no error flags. Then PUSH 0x7E -> sp=0, stack[31]=0x7E.
- clear asserted together with PUSH at sp=2 with errors set -> sp=0, flags 0, no op_done. Next PUSH 0x01 -> top=0x01.
- Assert rst_n low asynchronously between edges during a PUSH -> sp=0, top=0 immediately; op lost.
